alu_engine: RTL and testbench

ALU_ENGINE -- requirements
Module: alu_engine

---
 rtl/alu_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_alu_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_engine.sv
// Multi-function ALU engine: operand registers, edge-launched operations, single-cycle logic/arith
// ops plus iterative shift-add multiply and restoring divide, with registered result and flags.
module alu_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       selector,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             dbz
);

  localparam int unsigned CW  = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpNot  = 4'd5;
  localparam logic [3:0] OpShl  = 4'd6;
  localparam logic [3:0] OpShr  = 4'd7;
  localparam logic [3:0] OpRol  = 4'd8;
  localparam logic [3:0] OpRor  = 4'd9;
  localparam logic [3:0] OpMul  = 4'd10;
  localparam logic [3:0] OpDiv  = 4'd11;
  localparam logic [3:0] OpInc  = 4'd12;
  localparam logic [3:0] OpDec  = 4'd13;
  localparam logic [3:0] OpPass = 4'd14;
  localparam logic [3:0] OpRsv  = 4'd15;

  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] One      = (WIDTH+1)'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_sel;
  logic [CW-1:0]    count;
  logic             start_q;
  logic             start_rise;
  logic             last;

  // Shared iteration registers: MUL keeps {partial high, shifting multiplier},
  // DIV keeps {partial remainder, shifting dividend/quotient}.
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_next;
  logic [WIDTH-1:0]   div_quo_next;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH:0]   inc_full;
  logic [WIDTH:0]   dec_full;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;

  logic [WIDTH-1:0] res_y;
  logic [WIDTH-1:0] res_hi;
  logic             res_c;
  logic             res_z;
  logic             res_v;
  logic             res_dbz;
  logic             res_now;

  assign start_rise = start & ~start_q;
  assign last       = (count == LastCount);
  assign busy       = (state != StIdle);
  assign a_out      = a_reg;
  assign b_out      = b_reg;

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    mul_sum      = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_a} : '0);
    mul_next     = {mul_sum, work_lo[WIDTH-1:1]};
    div_shift    = {work_hi, work_lo[MSB]};
    div_diff     = div_shift - {1'b0, op_b};
    div_ge       = ~div_diff[WIDTH];
    div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_next = {work_lo[WIDTH-2:0], div_ge};
  end

  // Single-cycle operations.
  always_comb begin
    add_full = {1'b0, op_a} + {1'b0, op_b};
    sub_full = {1'b0, op_a} - {1'b0, op_b};
    inc_full = {1'b0, op_a} + One;
    dec_full = {1'b0, op_a} - One;
    alu_y    = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op_sel)
      OpAdd: begin
        alu_y = add_full[WIDTH-1:0];
        alu_c = add_full[WIDTH];
        alu_v = (op_a[MSB] == op_b[MSB]) && (alu_y[MSB] != op_a[MSB]);
      end
      OpSub: begin
        alu_y = sub_full[WIDTH-1:0];
        alu_c = sub_full[WIDTH];
        alu_v = (op_a[MSB] != op_b[MSB]) && (alu_y[MSB] != op_a[MSB]);
      end
      OpAnd: alu_y = op_a & op_b;
      OpOr:  alu_y = op_a | op_b;
      OpXor: alu_y = op_a ^ op_b;
      OpNot: alu_y = ~op_a;
      OpShl: begin
        alu_y = {op_a[WIDTH-2:0], 1'b0};
        alu_c = op_a[MSB];
      end
      OpShr: begin
        alu_y = {1'b0, op_a[MSB:1]};
        alu_c = op_a[0];
      end
      OpRol: alu_y = {op_a[WIDTH-2:0], op_a[MSB]};
      OpRor: alu_y = {op_a[0], op_a[MSB:1]};
      OpInc: begin
        alu_y = inc_full[WIDTH-1:0];
        alu_c = inc_full[WIDTH];
        alu_v = ~op_a[MSB] & alu_y[MSB];
      end
      OpDec: begin
        alu_y = dec_full[WIDTH-1:0];
        alu_c = dec_full[WIDTH];
        alu_v = op_a[MSB] & ~alu_y[MSB];
      end
      OpPass: alu_y = op_b;
      default: begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
      end
    endcase
  end

  // Result selection; res_now marks the RUN cycle that commits outputs.
  always_comb begin
    res_y   = '0;
    res_hi  = '0;
    res_c   = 1'b0;
    res_z   = 1'b0;
    res_v   = 1'b0;
    res_dbz = 1'b0;
    res_now = 1'b1;
    case (op_sel)
      OpMul: begin
        res_now = last;
        res_y   = mul_next[WIDTH-1:0];
        res_hi  = mul_next[2*WIDTH-1:WIDTH];
        res_v   = |mul_next[2*WIDTH-1:WIDTH];
        res_z   = ~|mul_next;
      end
      OpDiv: begin
        if (op_b == '0) begin
          res_y   = '1;
          res_hi  = op_a;
          res_dbz = 1'b1;
        end else begin
          res_now = last;
          res_y   = div_quo_next;
          res_hi  = div_rem_next;
          res_z   = ~|div_quo_next;
        end
      end
      OpRsv: res_now = 1'b1;
      default: begin
        res_y = alu_y;
        res_c = alu_c;
        res_v = alu_v;
        res_z = ~|alu_y;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= StIdle;
      a_reg   <= '0;
      b_reg   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_sel  <= '0;
      count   <= '0;
      start_q <= 1'b0;
      work_hi <= '0;
      work_lo <= '0;
      y       <= '0;
      y_hi    <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      dbz     <= 1'b0;
      done    <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      case (state)
        StIdle: begin
          if (load_a) a_reg <= data_in;
          if (load_b) b_reg <= data_in;
          if (start_rise) begin
            op_a    <= a_reg;
            op_b    <= b_reg;
            op_sel  <= selector;
            count   <= '0;
            work_hi <= '0;
            work_lo <= (selector == OpDiv) ? a_reg : b_reg;
            state   <= StRun;
          end
        end
        StRun: begin
          count <= count + 1'b1;
          if (op_sel == OpMul) begin
            work_hi <= mul_next[2*WIDTH-1:WIDTH];
            work_lo <= mul_next[WIDTH-1:0];
          end else begin
            work_hi <= div_rem_next;
            work_lo <= div_quo_next;
          end
          if (res_now) begin
            y     <= res_y;
            y_hi  <= res_hi;
            carry <= res_c;
            zero  <= res_z;
            ovf   <= res_v;
            dbz   <= res_dbz;
            done  <= 1'b1;
            state <= StFin;
          end
        end
        StFin:   state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_engine.sv
// Bench for alu_engine: directed vector table, multi-cycle corner sequences and random
// operations checked against an integer-arithmetic reference model.
module tb_alu_engine;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] y;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         v;
    logic         dbz;
    logic [7:0]   lat;
  } res_t;

  typedef struct packed {
    logic [3:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         exp;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data_in = '0;
  logic [3:0]   selector = '0;
  logic         load_a = 1'b0;
  logic         load_b = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_out, b_out, y, y_hi;
  logic         busy, done, carry, zero, ovf, dbz;

  int n_checks = 0;
  int n_fail = 0;

  alu_engine #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .selector(selector),
    .load_a(load_a), .load_b(load_b), .start(start),
    .a_out(a_out), .b_out(b_out), .y(y), .y_hi(y_hi),
    .busy(busy), .done(done), .carry(carry), .zero(zero), .ovf(ovf), .dbz(dbz)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic sovf(input longint s);
    return (s > longint'((1 << (W - 1)) - 1)) || (s < -longint'(1 << (W - 1)));
  endfunction

  // Reference model from the operation definitions, using plain integer arithmetic.
  function automatic res_t model(input logic [3:0] sel, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    res_t r;
    longint unsigned ua, ub, p, m;
    longint sa, sb;
    ua = 64'(a);
    ub = 64'(b);
    m  = (64'd1 << W) - 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    r.lat = 8'd2;
    case (sel)
      4'd0: begin p = ua + ub; r.y = W'(p); r.c = p > m; r.v = sovf(sa + sb); end
      4'd1: begin r.y = W'(ua - ub); r.c = ua < ub; r.v = sovf(sa - sb); end
      4'd2: r.y = a & b;
      4'd3: r.y = a | b;
      4'd4: r.y = a ^ b;
      4'd5: r.y = ~a;
      4'd6: begin r.y = W'(ua * 2); r.c = ua >= (64'd1 << (W - 1)); end
      4'd7: begin r.y = W'(ua / 2); r.c = (ua % 2) == 1; end
      4'd8: r.y = W'((ua * 2) | (ua >> (W - 1)));
      4'd9: r.y = W'((ua / 2) | ((ua % 2) << (W - 1)));
      4'd10: begin
        p = ua * ub;
        r.y = W'(p);
        r.hi = W'(p >> W);
        r.v = (p >> W) != 0;
        r.lat = 8'(W + 1);
      end
      4'd11: begin
        if (ub == 0) begin
          r.y = W'(m);
          r.hi = a;
          r.dbz = 1'b1;
        end else begin
          r.y = W'(ua / ub);
          r.hi = W'(ua % ub);
          r.lat = 8'(W + 1);
        end
      end
      4'd12: begin p = ua + 1; r.y = W'(p); r.c = p > m; r.v = sovf(sa + 1); end
      4'd13: begin r.y = W'(ua - 1); r.c = ua == 0; r.v = sovf(sa - 1); end
      4'd14: r.y = b;
      default: ;
    endcase
    if (sel != 4'd15) r.z = (r.y == '0) && (r.hi == '0 || sel != 4'd10);
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] yv, input logic [W-1:0] hv, input logic c,
                              input logic z, input logic v, input logic d, input int lat);
    vec_t t;
    t.sel = sel;
    t.a = a;
    t.b = b;
    t.exp.y = yv;
    t.exp.hi = hv;
    t.exp.c = c;
    t.exp.z = z;
    t.exp.v = v;
    t.exp.dbz = d;
    t.exp.lat = 8'(lat);
    return t;
  endfunction

  // All stimulus tasks start and end on a falling edge.
  task automatic load_ops(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    data_in = a;
    load_a = 1'b1;
    @(negedge clock);
    load_a = 1'b0;
    data_in = b;
    load_b = 1'b1;
    @(negedge clock);
    load_b = 1'b0;
    data_in = W'($urandom);
    check({name, ".a_out"}, 64'(a_out), 64'(a));
    check({name, ".b_out"}, 64'(b_out), 64'(b));
  endtask

  task automatic execute(input string name, input logic [3:0] sel, input logic [W-1:0] a,
                         input logic [W-1:0] b, input res_t e);
    int lat;
    int bc;
    load_ops(name, a, b);
    selector = sel;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    // The launched operation must ignore later selector changes.
    selector = 4'($urandom_range(0, 15));
    lat = 0;
    bc = 0;
    for (int i = 1; i <= 60; i++) begin
      if (busy) bc++;
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clock);
    end
    check({name, ".latency"}, 64'(lat), 64'(e.lat));
    check({name, ".busy_cycles"}, 64'(bc), 64'(e.lat));
    check({name, ".y"}, 64'(y), 64'(e.y));
    check({name, ".y_hi"}, 64'(y_hi), 64'(e.hi));
    check({name, ".flags"}, 64'({carry, zero, ovf, dbz}), 64'({e.c, e.z, e.v, e.dbz}));
    @(negedge clock);
    check({name, ".after_done"}, 64'({busy, done}), 64'(2'b00));
  endtask

  vec_t tbl[20];
  int   dcnt;
  logic [3:0]   rs;
  logic [W-1:0] ra, rb;

  initial begin
    tbl[0]  = mk(4'd0,  8'h05, 8'h03, 8'h08, 8'h00, 0, 0, 0, 0, 2);
    tbl[1]  = mk(4'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 1, 1, 0, 0, 2);
    tbl[2]  = mk(4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 0, 0, 1, 0, 2);
    tbl[3]  = mk(4'd10, 8'h0F, 8'h11, 8'hFF, 8'h00, 0, 0, 0, 0, 9);
    tbl[4]  = mk(4'd10, 8'hFF, 8'hFF, 8'h01, 8'hFE, 0, 0, 1, 0, 9);
    tbl[5]  = mk(4'd11, 8'h64, 8'h07, 8'h0E, 8'h02, 0, 0, 0, 0, 9);
    tbl[6]  = mk(4'd11, 8'h64, 8'h00, 8'hFF, 8'h64, 0, 0, 0, 1, 2);
    tbl[7]  = mk(4'd1,  8'h03, 8'h05, 8'hFE, 8'h00, 1, 0, 0, 0, 2);
    tbl[8]  = mk(4'd1,  8'h80, 8'h01, 8'h7F, 8'h00, 0, 0, 1, 0, 2);
    tbl[9]  = mk(4'd6,  8'h81, 8'h00, 8'h02, 8'h00, 1, 0, 0, 0, 2);
    tbl[10] = mk(4'd9,  8'h01, 8'h00, 8'h80, 8'h00, 0, 0, 0, 0, 2);
    tbl[11] = mk(4'd13, 8'h00, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 0, 2);
    tbl[12] = mk(4'd12, 8'h7F, 8'h00, 8'h80, 8'h00, 0, 0, 1, 0, 2);
    tbl[13] = mk(4'd15, 8'h12, 8'h34, 8'h00, 8'h00, 0, 0, 0, 0, 2);
    tbl[14] = mk(4'd14, 8'h12, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 2);
    tbl[15] = mk(4'd10, 8'h00, 8'h37, 8'h00, 8'h00, 0, 1, 0, 0, 9);
    tbl[16] = mk(4'd11, 8'h05, 8'h09, 8'h00, 8'h05, 0, 1, 0, 0, 9);
    tbl[17] = mk(4'd7,  8'h01, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 2);
    tbl[18] = mk(4'd5,  8'hAA, 8'h00, 8'h55, 8'h00, 0, 0, 0, 0, 2);
    tbl[19] = mk(4'd8,  8'h80, 8'h00, 8'h01, 8'h00, 0, 0, 0, 0, 2);

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_state", 64'({a_out, b_out, y, y_hi, busy, done, carry, zero, ovf, dbz}), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 20; i++)
      execute($sformatf("vec%0d", i), tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].exp);

    // Held start level launches exactly one operation
    load_ops("hold", 8'h05, 8'h03);
    selector = 4'd0;
    start = 1'b1;
    dcnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) dcnt++;
    end
    start = 1'b0;
    @(negedge clock);
    check("hold.done_count", 64'(dcnt), 64'd1);
    check("hold.y", 64'(y), 64'h08);

    // Loads and start edges during a multiply are ignored
    load_ops("busyload", 8'h03, 8'h05);
    selector = 4'd10;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    load_a = 1'b1;
    data_in = 8'hAA;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    load_a = 1'b0;
    dcnt = 0;
    repeat (15) begin
      if (done) dcnt++;
      @(negedge clock);
    end
    check("busyload.done_count", 64'(dcnt), 64'd1);
    check("busyload.a_out", 64'(a_out), 64'h03);
    check("busyload.product", 64'({y_hi, y}), 64'h000F);

    // Reset in the middle of a multiply, then start held through reset release
    load_ops("midreset", 8'h0F, 8'h11);
    selector = 4'd10;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset.outputs",
          64'({a_out, b_out, y, y_hi, busy, done, carry, zero, ovf, dbz}), 64'd0);
    selector = 4'd12;
    start = 1'b1;
    dcnt = 0;
    repeat (2) begin
      @(negedge clock);
      if (done) dcnt++;
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (done) dcnt++;
    end
    start = 1'b0;
    @(negedge clock);
    check("midreset.done_count", 64'(dcnt), 64'd1);
    check("midreset.inc_result", 64'({y_hi, y, carry, zero, ovf}), 64'({8'h00, 8'h01, 3'b000}));
    check("midreset.idle", 64'({busy, done}), 64'd0);
    execute("post_reset_add", 4'd0, 8'h05, 8'h03, model(4'd0, 8'h05, 8'h03));

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rs = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      execute($sformatf("rand%0d_op%0d_%02h_%02h", i, rs, ra, rb), rs, ra, rb, model(rs, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
